// File: rtl/temporal_pkg.sv
// Shared types and helpers for the binary-to-race-logic encoder.
// Build option: TEMPORAL_FALLING_EN selects falling-edge lane encoding.
package temporal_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

  function automatic int phase_width(input int g);
    return $clog2(g);
  endfunction

  function automatic int inf_val(input int g);
    return g - 1;
  endfunction

endpackage

// File: rtl/gamma_phase_counter.sv
// Phase counter for one gamma cycle; wraps G-1 -> 0 naturally.
// Held at zero while not running so IDLE always sits on phase 0.
module gamma_phase_counter
  import temporal_pkg::*;
#(
  parameter int G = 16,
  parameter int W = phase_width(G)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         load,
  output logic [W-1:0] phase,
  output logic         last
);

  logic [W-1:0] r_phase;

  // count while running; a new vector restarts at phase 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
    end else if (load) begin
      r_phase <= '0;
    end else if (run) begin
      r_phase <= r_phase + W'(1);
    end else begin
      r_phase <= '0;
    end
  end

  assign phase = r_phase;
  assign last  = (r_phase == W'(inf_val(G)));

endmodule

// File: rtl/temporal_encoder_n.sv
// Binary arrival times -> race-logic edges with grst framing.
// Build option: TEMPORAL_FALLING_EN inverts lanes (fall at v+1).
module temporal_encoder_n
  import temporal_pkg::*;
#(
  parameter int NUM_INPUTS        = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int VAL_WIDTH         = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_INPUTS*VAL_WIDTH-1:0] in_vals,
  output logic                            grst,
  output logic [NUM_INPUTS-1:0]           y,
  output logic                            cycle_start,
  output logic                            busy
);

  localparam int N  = NUM_INPUTS;
  localparam int VW = VAL_WIDTH;
  localparam int NV = N * VW;
  localparam logic [VW-1:0] INF =
    VW'(inf_val(GAMMA_CYCLE_WIDTH));
`ifdef TEMPORAL_FALLING_EN
  localparam logic [N-1:0] Y_RST = '1;
`else
  localparam logic [N-1:0] Y_RST = '0;
`endif

  enc_state_t    r_state;
  enc_state_t    w_nxt_state;
  logic          r_pend_vld;
  logic          r_in_ready;
  logic          r_grst;
  logic          r_cs;
  logic          r_busy;
  logic [NV-1:0] r_pend_vals;
  logic [NV-1:0] r_act;
  logic [NV-1:0] w_nxt_act;
  logic [N-1:0]  r_y;
  logic [N-1:0]  w_nxt_y;
  logic [VW-1:0] w_phase;
  logic [VW-1:0] w_nxt_phase;
  logic [VW-1:0] w_lane;
  logic          w_last;
  logic          w_load;
  logic          w_take;
  logic          w_nxt_pend;
  logic          w_run;

  assign w_run  = (r_state == RUN);
  assign w_take = in_valid && !r_pend_vld;
  assign w_load = r_pend_vld && (!w_run || w_last);

  gamma_phase_counter #(
    .G (GAMMA_CYCLE_WIDTH),
    .W (VW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .run   (w_run),
    .load  (w_load),
    .phase (w_phase),
    .last  (w_last)
  );

  // next state, phase, pending and active vector
  always_comb begin
    w_nxt_state = r_state;
    unique case (r_state)
      IDLE: if (r_pend_vld) w_nxt_state = RUN;
      RUN:  if (w_last && !r_pend_vld) w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
    w_nxt_phase = (w_load || !w_run) ? '0 : w_phase + VW'(1);
    w_nxt_act   = w_load ? r_pend_vals : r_act;
    w_nxt_pend  = w_take ? 1'b1 : (w_load ? 1'b0 : r_pend_vld);
  end

  // per-lane edge compare on next-cycle phase
  always_comb begin
    w_nxt_y = '0;
    w_lane  = '0;
    for (int i = 0; i < N; i++) begin
      w_lane = w_nxt_act[i*VW +: VW];
      w_nxt_y[i] = (w_nxt_state == RUN) && (w_lane != INF)
                   && (w_nxt_phase > w_lane);
    end
`ifdef TEMPORAL_FALLING_EN
    w_nxt_y = ~w_nxt_y;
`endif
  end

  // state, storage and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pend_vld  <= 1'b0;
      r_pend_vals <= '0;
      r_act       <= '1;
      r_in_ready  <= 1'b1;
      r_grst      <= 1'b1;
      r_cs        <= 1'b0;
      r_busy      <= 1'b0;
      r_y         <= Y_RST;
    end else begin
      r_state    <= w_nxt_state;
      r_pend_vld <= w_nxt_pend;
      if (w_take) r_pend_vals <= in_vals;
      r_act      <= w_nxt_act;
      r_in_ready <= !w_nxt_pend;
      r_grst     <= (w_nxt_state == IDLE) || (w_nxt_phase == '0);
      r_cs       <= (w_nxt_state == RUN) && (w_nxt_phase == '0);
      r_busy     <= (w_nxt_state == RUN);
      r_y        <= w_nxt_y;
    end
  end

  assign in_ready    = r_in_ready;
  assign grst        = r_grst;
  assign cycle_start = r_cs;
  assign busy        = r_busy;
  assign y           = r_y;

endmodule

// File: tb/tb_temporal_encoder_n.sv
// Bench for temporal_encoder_n (G=16, N=4) against a cycle model.
// Build option: TEMPORAL_FALLING_EN expects inverted lanes.
module tb_temporal_encoder_n;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vals;
  logic        grst;
  logic [3:0]  y;
  logic        cycle_start;
  logic        busy;

  int n_vec;
  int n_cmp;
  int errs;

  bit          m_busy;
  int          m_t;
  int          m_act [4];
  logic [15:0] pq [$];

  temporal_encoder_n #(
    .NUM_INPUTS        (4),
    .GAMMA_CYCLE_WIDTH (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vals     (in_vals),
    .grst        (grst),
    .y           (y),
    .cycle_start (cycle_start),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s vec=%0d obs=%0h exp=%0h", tag, n_vec, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_y();
    logic [3:0] e;
    for (int i = 0; i < 4; i++)
      e[i] = m_busy && (m_act[i] != 15) && (m_t >= m_act[i] + 1);
`ifdef TEMPORAL_FALLING_EN
    e = ~e;
`endif
    return e;
  endfunction

  task automatic model_edge(input bit r, input bit v,
                            input logic [15:0] vals);
    bit took;
    logic [15:0] nx;
    if (r) begin
      m_busy = 0;
      m_t    = 0;
      pq.delete();
      for (int i = 0; i < 4; i++) m_act[i] = 15;
      return;
    end
    took = v && (pq.size() == 0);
    if (m_busy && m_t < 15) begin
      m_t++;
    end else if (pq.size() != 0) begin
      nx = pq.pop_front();
      m_busy = 1;
      m_t    = 0;
      for (int i = 0; i < 4; i++) m_act[i] = int'(nx[4*i +: 4]);
    end else begin
      m_busy = 0;
      m_t    = 0;
    end
    if (took) pq.push_back(vals);
  endtask

  task automatic check_all();
    chk("grst", {3'b0, grst}, {3'b0, (!m_busy || m_t == 0)});
    chk("cycle_start", {3'b0, cycle_start},
        {3'b0, (m_busy && m_t == 0)});
    chk("busy", {3'b0, busy}, {3'b0, m_busy});
    chk("in_ready", {3'b0, in_ready}, {3'b0, (pq.size() == 0)});
    chk("y", y, exp_y());
  endtask

  task automatic step(input bit r, input bit v,
                      input logic [15:0] vals, output bit took);
    rst      = r;
    in_valid = v;
    in_vals  = vals;
    took     = !r && v && (pq.size() == 0);
    @(posedge clk);
    model_edge(r, v, vals);
    n_vec++;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    bit t;
    for (int k = 0; k < n; k++) step(0, 0, 16'($urandom), t);
  endtask

  task automatic send(input logic [15:0] vec);
    bit t;
    bit done;
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      step(0, 1, vec, t);
      done = t;
    end
    n_cmp++;
    if (!done) begin
      errs++;
      $error("FAIL send_timeout vec=%0h obs=stalled exp=accepted", vec);
    end
  endtask

  initial begin
    bit t;
    bit hit;
    n_vec = 0;
    n_cmp = 0;
    errs  = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_vals = '0;
    m_busy = 0;
    m_t = 0;
    for (int i = 0; i < 4; i++) m_act[i] = 15;

    step(1, 0, 16'h0, t);
    step(1, 0, 16'h0, t);
    chk("rst_y_direct", y,
`ifdef TEMPORAL_FALLING_EN
        4'hf);
`else
        4'h0);
`endif
    idle(2);

    send({4'd15, 4'd14, 4'd3, 4'd0});
    idle(22);

    send({4'd5, 4'd15, 4'd0, 4'd2});
    idle(22);

    send({4'd1, 4'd2, 4'd3, 4'd4});
    send({4'd8, 4'd0, 4'd15, 4'd7});
    send({4'd14, 4'd13, 4'd12, 4'd11});
    idle(60);

    send({4'd6, 4'd6, 4'd6, 4'd6});
    send({4'd2, 4'd9, 4'd0, 4'd15});
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (m_busy && m_t == 7 && pq.size() == 1) hit = 1;
      else step(0, 0, 16'($urandom), t);
    end
    n_cmp++;
    if (!hit) begin
      errs++;
      $error("FAIL reach_phase7 obs=missed exp=phase7_pending");
    end
    step(1, 0, 16'h0, t);
    idle(24);

    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
           16'($urandom), t);
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
    $finish;
  end

endmodule

// File: doc/temporal_encoder_n.md
Name: temporal_encoder_N

Overview:
- Binary-to-race-logic front end for the temporal mux/equal array.
- Accepts a vector of NUM_INPUTS binary arrival times over a valid/ready handshake and runs gamma cycles of GAMMA_CYCLE_WIDTH clocks.
- Each gamma cycle begins with a grst phase, then each lane emits a rising edge at its encoded time.
- Drives the downstream mux's grst, inputs and select_line lanes directly.

Parameters:
- NUM_INPUTS, 4: number of temporal lanes.
- GAMMA_CYCLE_WIDTH, 16: clocks per gamma cycle, G. Must be a power of 2 and at least 4.
- VAL_WIDTH, $clog2(GAMMA_CYCLE_WIDTH): width of each binary time value.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  encoder can accept a vector.
- in_vals  in  NUM_INPUTS*VAL_WIDTH  packed times; lane i is in_vals[i*VAL_WIDTH +: VAL_WIDTH].
- grst  out  1  gamma reset to downstream stages.
- y  out  NUM_INPUTS  temporal edge lanes.
- cycle_start  out  1  one-clock strobe on phase 0 of every RUN cycle.
- busy  out  1  state is RUN.

Behaviour:
- Storage: one pending register (pend_vld, pend_vals) and one active register (act_vals).
- Handshake:
  - in_ready = !pend_vld. No bypass: in_ready stays low in the cycle pending is drained.
  - Transfer occurs when in_valid && in_ready at a rising edge; pend_vld is 1 the next cycle.
  - in_vals are ignored when no transfer occurs.
- FSM states:
  - IDLE: phase=0, grst=1, y=0, busy=0.
    - If pend_vld: act<=pend_vals, pend_vld<=0, go to RUN with phase=0.
  - RUN: phase increments by 1 each clock, from 0 to G-1.
    - At phase G-1 with pend_vld: load act, clear pend_vld, set phase<=0, stay in RUN (no idle gap).
    - At phase G-1 without pend_vld: go to IDLE.
- Output timing (all outputs registered, glitch-free, no combinational path from inputs):
  - grst = 1 in IDLE and in RUN phase 0; otherwise 0.
  - cycle_start = 1 in RUN phase 0 only.
  - y[i] = 1 in RUN when phase >= act[i]+1 and act[i] != G-1; otherwise 0.
  - Value v in 0..G-2 rises at phase v+1 and holds until the cycle ends.
  - Value G-1 encodes infinity: the lane never rises.
  - All y drop to 0 at the next phase 0 or on entry to IDLE.
- Latency: accept at edge k means RUN phase 0 (grst=1, cycle_start=1) is visible in cycle k+2 when starting from IDLE.
- Reset values: state=IDLE, phase=0, pend_vld=0, act=all-ones (infinity), in_ready=1, grst=1, y=0, cycle_start=0, busy=0.
- Reset mid-operation:
  - The next cycle shows the reset values.
  - Pending and active vectors are discarded; no partial edges remain.
- Counter wrap: phase is VAL_WIDTH bits and wraps naturally from G-1 to 0. No other wrap is legal.

Optional Feature:
- Macro: TEMPORAL_FALLING_EN.
- Defined: falling-edge encoding.
  - y[i] = 1 in IDLE and from phase 0 of RUN.
  - Lane falls at phase v+1; infinity stays high all cycle.
  - Reset value of y is all-ones.
  - grst, cycle_start and the handshake are unchanged.
- Undefined: rising-edge encoding as described above.

Decomposition:
- temporal_pkg holds:
  - enum enc_state_t {IDLE, RUN};
  - function phase_width(G) returning $clog2(G);
  - localparam-style helper INF_VAL(G) = G-1.
- One sub-module: gamma_phase_counter.
  - Ports: clk, rst, run, load.
  - Outputs: phase, last (phase==G-1).
  - The top holds the FSM, the pending/active registers and the edge compare.

Test Plan (G=16, N=4):
- Reset: rst high 2 cycles -> grst=1, y=0, in_ready=1, busy=0, cycle_start=0.
- Single vector {lane0=0, lane1=3, lane2=14, lane3=15}:
  - cycle_start at phase 0.
  - y[0] rises at phase 1, y[1] at phase 4, y[2] at phase 15; y[3] stays 0.
  - After phase 15: IDLE, grst=1, y=0.
- Back-to-back vectors A then B: in_ready drops after B is accepted and rises the cycle after B loads at A's phase 15. B's phase 0 immediately follows A's phase 15 with no IDLE cycle.
- Third vector C offered while pending is full: in_ready=0, C is not taken. C is held by the source and accepted only after the pending register drains.
- rst asserted at RUN phase 7 with pending valid: the next cycle shows the reset values, and a following cycle_start occurs only after a new accept.
- TEMPORAL_FALLING_EN, vector {2,0,15,5}: y resets to 4'b1111. Lane 0 falls at phase 3, lane 1 at phase 1, lane 3 at phase 6; lane 2 stays high.
